line_fetch_sched: RTL and testbench

//  Read-side scheduler for the float_mult input path. Issues 512-bit line read requests
//  to the host memory interface and steers read responses into the 512->64 unpacking buffer.

---
 rtl/float_mult_pkg.sv | 18 +
 rtl/word_skid2.sv | 70 +++++++
 rtl/line_fetch_sched.sv | 165 ++++++++++++++++
 tb/tb_line_fetch_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_mult_pkg.sv
// Shared types and constants for the float_mult input path.
//   fetch_state_t  : read-side scheduler state (IDLE, FETCH, DRAIN)
//   WORDS_PER_LINE : 64-bit words per 512-bit host line
//   LINE_BYTES     : bytes per host line
//   WORD_IDX_W     : bits needed to index a word within a line
package float_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_BYTES     = 64;
    localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);

endpackage

// File: rtl/word_skid2.sv
// Two-entry 64-bit skid FIFO between the unpacking buffer read port and the
// multiplier stream. The write side has no ready: the scheduler only pops the
// unpacking buffer when it knows a slot will be free when the word lands.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_in_valid    word arriving this cycle (buffer dout one cycle after pop)
//   i_in_data     arriving word
//   o_out_valid   head entry present
//   o_out_data    head entry
//   i_out_ready   consumer takes head when o_out_valid && i_out_ready
//   o_occ         entries held (0..2)
module word_skid2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_in_valid,
    input  logic [63:0] i_in_data,
    output logic        o_out_valid,
    output logic [63:0] o_out_data,
    input  logic        i_out_ready,
    output logic [1:0]  o_occ
);

    logic [63:0] r_data0;   // head
    logic [63:0] r_data1;   // second entry
    logic [1:0]  r_occ;
    logic        w_push;
    logic        w_pop;

    assign w_push      = i_in_valid;
    assign w_pop       = o_out_valid && i_out_ready;
    assign o_out_valid = (r_occ != 2'd0);
    assign o_out_data  = r_data0;
    assign o_occ       = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_occ   <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= i_in_data;
                        r_occ   <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_data1 <= i_in_data;
                        r_occ   <= 2'd2;
                    end
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word goes behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_data0 <= i_in_data;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= i_in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/line_fetch_sched.sv
// Read-side scheduler for the float_mult input path. Issues line read requests
// to the host memory interface, steers read responses into the 512->64
// unpacking buffer, and drains that buffer as a 64-bit stream. A credit
// counter bounds lines in flight plus lines resident in the buffer.
//
// Handshakes: a word transfers on o_word_valid && i_word_ready; valid never
// depends on ready. Read requests have no ready: o_rd_req_valid high is an
// issue, and it is never raised while i_rd_req_almfull is high.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_start            job start pulse, honoured only in IDLE
//   i_base_addr        first line address (sampled on accepted start)
//   i_num_lines        job length in lines (0 = empty job)
//   o_busy             job in progress
//   o_done             pulse the cycle after the last word is accepted
//   o_rd_req_valid     line read request issued this cycle
//   o_rd_req_addr      line read address
//   i_rd_req_almfull   memory interface back-pressure
//   i_rd_rsp_valid     512-bit response arriving this cycle
//   o_buf_wr_en        unpacking buffer write enable
//   o_buf_rd_en        unpacking buffer 64-bit pop
//   i_buf_empty        unpacking buffer empty
//   i_buf_dout         buffer word, valid one cycle after o_buf_rd_en
//   o_word_valid       output word valid
//   o_word_data        output word
//   i_word_ready       downstream ready
//   o_state            current scheduler state (debug)
module line_fetch_sched
    import float_mult_pkg::*;
#(
    parameter int ADDR_W      = 42,
    parameter int LEN_W       = 20,
    parameter int MAX_CREDITS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_num_lines,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_req_valid,
    output logic [ADDR_W-1:0] o_rd_req_addr,
    input  logic              i_rd_req_almfull,
    input  logic              i_rd_rsp_valid,
    output logic              o_buf_wr_en,
    output logic              o_buf_rd_en,
    input  logic              i_buf_empty,
    input  logic [63:0]       i_buf_dout,
    output logic              o_word_valid,
    output logic [63:0]       o_word_data,
    input  logic              i_word_ready,
    output fetch_state_t      o_state
);

    localparam int CRED_W = $clog2(MAX_CREDITS + 1);
    localparam int WCNT_W = LEN_W + WORD_IDX_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_num_lines;
    logic [LEN_W-1:0]  r_req_cnt;
    logic [CRED_W-1:0] r_credits;
    logic [WCNT_W-1:0] r_popped;
    logic [WCNT_W-1:0] r_accepted;
    logic              r_inflight;   // buffer word lands in the skid this cycle
    logic              r_done;

    logic              w_start_ok;
    logic              w_issue;
    logic              w_last_req;
    logic              w_accept;
    logic              w_last_word;
    logic              w_return;
    logic [WCNT_W-1:0] w_total;
    logic [1:0]        w_occ;
    logic [2:0]        w_fill;

    assign w_start_ok = (r_state == IDLE) && i_start;
    assign w_total    = {r_num_lines, {WORD_IDX_W{1'b0}}};
    assign w_issue    = (r_state == FETCH) && !i_rd_req_almfull && (r_credits != '0);
    assign w_last_req = w_issue && (({1'b0, r_req_cnt} + 1'b1) == {1'b0, r_num_lines});
    assign w_accept   = o_word_valid && i_word_ready;
    assign w_last_word = w_accept && (r_state == DRAIN) && (r_accepted == (w_total - 1'b1));

    // Skid fill one cycle from now if we do not pop: only pop when that
    // leaves a free slot for the word this pop will produce.
    assign w_fill = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_accept};

    assign o_buf_rd_en = o_busy && !i_buf_empty && (r_popped < w_total) && (w_fill < 3'd2);

    // A line's credit comes back once its last word leaves the buffer.
    assign w_return = o_buf_rd_en &&
                      (r_popped[WORD_IDX_W-1:0] == WORD_IDX_W'(WORDS_PER_LINE - 1));

    assign o_busy         = (r_state != IDLE);
    assign o_done         = r_done;
    assign o_rd_req_valid = w_issue;
    assign o_rd_req_addr  = r_addr;
    assign o_buf_wr_en    = i_rd_rsp_valid && o_busy;
    assign o_state        = r_state;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start && (i_num_lines != '0)) w_state_next = FETCH;
            FETCH:   if (w_last_req) w_state_next = DRAIN;
            DRAIN:   if (w_last_word) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_num_lines <= '0;
            r_req_cnt   <= '0;
            r_credits   <= CRED_W'(MAX_CREDITS);
            r_popped    <= '0;
            r_accepted  <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= (w_start_ok && (i_num_lines == '0)) || w_last_word;
            r_inflight <= o_buf_rd_en;

            if (w_start_ok) begin
                r_addr      <= i_base_addr;
                r_num_lines <= i_num_lines;
                r_req_cnt   <= '0;
                r_popped    <= '0;
                r_accepted  <= '0;
            end else begin
                if (w_issue) begin
                    r_addr    <= r_addr + 1'b1;
                    r_req_cnt <= r_req_cnt + 1'b1;
                end
                if (o_buf_rd_en) r_popped <= r_popped + 1'b1;
                if (w_accept)    r_accepted <= r_accepted + 1'b1;
            end

            if (w_issue && !w_return) begin
                r_credits <= r_credits - 1'b1;
            end else if (!w_issue && w_return) begin
                r_credits <= r_credits + 1'b1;
            end
        end
    end

    word_skid2 u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (r_inflight),
        .i_in_data   (i_buf_dout),
        .o_out_valid (o_word_valid),
        .o_out_data  (o_word_data),
        .i_out_ready (i_word_ready),
        .o_occ       (w_occ)
    );

endmodule

// File: tb/tb_line_fetch_sched.sv
module tb_line_fetch_sched;
  import float_mult_pkg::*;

  localparam int ADDR_W      = 42;
  localparam int LEN_W       = 20;
  localparam int MAX_CREDITS = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              i_start = 1'b0;
  logic [ADDR_W-1:0] i_base_addr = '0;
  logic [LEN_W-1:0]  i_num_lines = '0;
  logic              o_busy, o_done, o_rd_req_valid;
  logic [ADDR_W-1:0] o_rd_req_addr;
  logic              i_rd_req_almfull = 1'b0;
  logic              i_rd_rsp_valid = 1'b0;
  logic              o_buf_wr_en, o_buf_rd_en;
  logic              i_buf_empty = 1'b1;
  logic [63:0]       i_buf_dout = '0;
  logic              o_word_valid;
  logic [63:0]       o_word_data;
  logic              i_word_ready = 1'b0;
  fetch_state_t      o_state;

  line_fetch_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CREDITS(MAX_CREDITS)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_base_addr      (i_base_addr),
    .i_num_lines      (i_num_lines),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_rd_req_valid   (o_rd_req_valid),
    .o_rd_req_addr    (o_rd_req_addr),
    .i_rd_req_almfull (i_rd_req_almfull),
    .i_rd_rsp_valid   (i_rd_rsp_valid),
    .o_buf_wr_en      (o_buf_wr_en),
    .o_buf_rd_en      (o_buf_rd_en),
    .i_buf_empty      (i_buf_empty),
    .i_buf_dout       (i_buf_dout),
    .o_word_valid     (o_word_valid),
    .o_word_data      (o_word_data),
    .i_word_ready     (i_word_ready),
    .o_state          (o_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Content of word k of the line at address a, as the host would return it.
  function automatic logic [63:0] mkword(input logic [ADDR_W-1:0] a, input logic [2:0] k);
    return {a, 19'h2B3C1, k};
  endfunction

  // ---------------- behavioural model state ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } rsp_t;

  logic [63:0]       exp_q[$];   // words the stream must deliver, in order
  logic [63:0]       buf_q[$];   // unpacking buffer contents
  rsp_t              rsp_q[$];   // host responses pending
  bit                busy_m = 1'b0;
  bit                done_exp = 1'b0;
  int                job_n = 0;
  logic [ADDR_W-1:0] job_base = '0;
  int                n_issued = 0, n_popped = 0, n_accepted = 0, n_done_seen = 0;
  logic [ADDR_W-1:0] first_req_addr = '0;
  logic [63:0]       first_word = '0;
  logic [63:0]       dout_v = '0;
  logic [ADDR_W-1:0] cur_rsp = '0;
  int                t_last_acc = 0, t_done = 0;
  int                cyc = 0;

  // stimulus controls
  int                ready_mode = 1;  // 0 low, 1 high, 2 random
  int                alm_mode = 0;    // 0 low, 1 toggle every 3 cycles, 2 random
  int                lat_min = 2, lat_max = 2;
  bit                start_req = 1'b0;
  logic [ADDR_W-1:0] start_base = '0;
  logic [LEN_W-1:0]  start_n = '0;
  bit                rst_req = 1'b1;

  // ---------------- per-cycle driver + compare process ----------------
  initial begin : cycle_loop
    bit busy_now, done_next, exp_req;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_req) begin
        rst = 1'b1;
        i_start = 1'b0;
        i_rd_rsp_valid = 1'b0;
        i_buf_empty = 1'b1;
        #1;
        check1("rst_busy", o_busy, 1'b0);
        check1("rst_done", o_done, 1'b0);
        check1("rst_rd_req_valid", o_rd_req_valid, 1'b0);
        check1("rst_buf_rd_en", o_buf_rd_en, 1'b0);
        check1("rst_word_valid", o_word_valid, 1'b0);
        check64("rst_rd_req_addr", 64'(o_rd_req_addr), 64'h0);
        check1("rst_state_idle", o_state == IDLE, 1'b1);
        exp_q.delete(); buf_q.delete(); rsp_q.delete();
        busy_m = 1'b0; done_exp = 1'b0;
        job_n = 0; n_issued = 0; n_popped = 0; n_accepted = 0;
        rst_req = 1'b0;
        continue;
      end
      rst = 1'b0;

      // drive inputs for this cycle
      i_start = 1'b0;
      if (start_req) begin
        i_start = 1'b1;
        i_base_addr = start_base;
        i_num_lines = start_n;
        start_req = 1'b0;
      end
      case (alm_mode)
        1:       i_rd_req_almfull = ((cyc / 3) % 2) == 1;
        2:       i_rd_req_almfull = ($urandom_range(0, 3) == 0);
        default: i_rd_req_almfull = 1'b0;
      endcase
      case (ready_mode)
        0:       i_word_ready = 1'b0;
        2:       i_word_ready = $urandom_range(0, 1) == 1;
        default: i_word_ready = 1'b1;
      endcase
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        i_rd_rsp_valid = 1'b1;
        cur_rsp = rsp_q[0].addr;
        void'(rsp_q.pop_front());
      end else begin
        i_rd_rsp_valid = 1'b0;
      end
      i_buf_empty = (buf_q.size() == 0);
      i_buf_dout = dout_v;
      #1;

      // compare against model
      busy_now = busy_m;
      check1("busy", o_busy, busy_now);
      check1("done", o_done, done_exp);
      if (o_done) begin
        n_done_seen++;
        t_done = cyc;
      end
      exp_req = busy_now && (n_issued < job_n) && !i_rd_req_almfull &&
                ((n_issued - n_popped / 8) < MAX_CREDITS);
      check1("rd_req_valid", o_rd_req_valid, exp_req);
      check1("buf_wr_en", o_buf_wr_en, i_rd_rsp_valid && busy_now);
      if (o_buf_rd_en) begin
        n_vec++;
        if (buf_q.size() == 0 || n_popped >= job_n * 8) begin
          n_err++;
          $display("FAIL pop_legal: pop with %0d buffered, %0d of %0d popped", buf_q.size(), n_popped, job_n * 8);
        end
      end

      // advance model
      if (o_rd_req_valid) begin
        check64("rd_req_addr", 64'(o_rd_req_addr), 64'(ADDR_W'(job_base + ADDR_W'(n_issued))));
        if (n_issued == 0) first_req_addr = o_rd_req_addr;
        rsp_q.push_back('{addr: o_rd_req_addr, due: cyc + $urandom_range(lat_min, lat_max)});
        n_issued++;
      end
      if (i_rd_rsp_valid && busy_now) begin
        for (int k = 0; k < 8; k++) buf_q.push_back(mkword(cur_rsp, 3'(k)));
        if (buf_q.size() > MAX_CREDITS * 8) begin
          n_vec++; n_err++;
          $display("FAIL buf_overflow: %0d words buffered, limit %0d", buf_q.size(), MAX_CREDITS * 8);
        end
      end
      if (o_buf_rd_en && buf_q.size() > 0) begin
        dout_v = buf_q.pop_front();
        n_popped++;
      end
      done_next = 1'b0;
      if (o_word_valid && i_word_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_word: got %h with nothing expected", o_word_data);
        end else begin
          check64("word_data", o_word_data, exp_q.pop_front());
          if (n_accepted == 0) first_word = o_word_data;
          n_accepted++;
          if (exp_q.size() == 0 && busy_now) begin
            done_next = 1'b1;
            busy_m = 1'b0;
            t_last_acc = cyc;
          end
        end
      end
      if (i_start && !busy_now) begin
        job_base = i_base_addr;
        job_n = int'(i_num_lines);
        n_issued = 0; n_popped = 0; n_accepted = 0;
        if (job_n == 0) begin
          done_next = 1'b1;
        end else begin
          busy_m = 1'b1;
          for (int i = 0; i < job_n; i++)
            for (int k = 0; k < 8; k++)
              exp_q.push_back(mkword(ADDR_W'(job_base + ADDR_W'(i)), 3'(k)));
        end
      end
      done_exp = done_next;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [ADDR_W-1:0] base, input int n);
    @(posedge clk);
    start_base = base;
    start_n = LEN_W'(n);
    start_req = 1'b1;
    while (start_req) @(posedge clk);
  endtask

  task automatic wait_done(input int budget, input string name);
    int base_cnt;
    int c;
    base_cnt = n_done_seen;
    c = 0;
    while (n_done_seen == base_cnt && c < budget) begin
      @(posedge clk);
      c++;
    end
    n_vec++;
    if (n_done_seen == base_cnt) begin
      n_err++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int d0;
    int c;
    repeat (3) @(posedge clk);

    // T1: single line, fixed 2-cycle latency
    ready_mode = 1; alm_mode = 0; lat_min = 2; lat_max = 2;
    start_job(42'h100, 1);
    wait_done(200, "t1_done");
    check_int("t1_reqs", n_issued, 1);
    check64("t1_req_addr", 64'(first_req_addr), 64'h100);
    check64("t1_first_word", first_word, 64'h0000_0000_4015_9E08);
    check_int("t1_words", n_accepted, 8);
    check_int("t1_done_delay", t_done - t_last_acc, 1);

    // T2: credit limit with stalled consumer
    ready_mode = 0; lat_min = 1; lat_max = 4;
    start_job(42'h2000, 300);
    repeat (400) @(posedge clk);
    check_int("t2_reqs_stalled", n_issued, 128);
    ready_mode = 1;
    wait_done(5000, "t2_done");
    check_int("t2_reqs", n_issued, 300);
    check_int("t2_words", n_accepted, 2400);

    // T3: almfull toggling, address wrap at 2^ADDR_W
    alm_mode = 1;
    start_job(42'h3FF_FFFF_FFF8, 20);
    wait_done(2000, "t3_done");
    check_int("t3_reqs", n_issued, 20);

    // T4: random back-pressure on both sides, start while busy ignored
    alm_mode = 2; ready_mode = 2; lat_min = 1; lat_max = 6;
    start_job(ADDR_W'({$urandom, $urandom}), 100);
    repeat (50) @(posedge clk);
    start_job(42'h5555, 7);
    wait_done(8000, "t4_done");
    check_int("t4_words", n_accepted, 800);

    // T5: empty job
    alm_mode = 0; ready_mode = 1; lat_min = 2; lat_max = 2;
    d0 = n_done_seen;
    start_job(42'h777, 0);
    wait_done(20, "t5_done");
    repeat (5) @(posedge clk);
    check_int("t5_done_count", n_done_seen - d0, 1);
    check_int("t5_reqs", n_issued, 0);

    // T6: reset in DRAIN, then a clean job with full credits
    start_job(42'h9000, 200);
    c = 0;
    while (o_state != DRAIN && c < 3000) begin
      @(negedge clk); #2;
      c++;
    end
    check1("t6_reached_drain", o_state == DRAIN, 1'b1);
    repeat (10) @(posedge clk);
    rst_req = 1'b1;
    while (rst_req) @(posedge clk);
    ready_mode = 0;
    start_job(42'hA000, 150);
    repeat (400) @(posedge clk);
    check_int("t6_reqs_stalled", n_issued, 128);
    ready_mode = 1;
    wait_done(4000, "t6_done");
    check_int("t6_words", n_accepted, 1200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
